// File: rtl/raymarch_frame_scheduler_pkg.sv
// raymarch_sched_pkg: shared FSM states, default frame geometry and PIO word offsets for the frame scheduler
package raymarch_sched_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, DISPATCH, DRAIN, DONE} state_t;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int PIO_W = 32;
  localparam int CFG_W_DEF = 17 * PIO_W;
  localparam int EYE_X_OFF = 16 * PIO_W;
  localparam int EYE_Y_OFF = 15 * PIO_W;
  localparam int EYE_Z_OFF = 14 * PIO_W;
  localparam int RED_OFF = 4 * PIO_W;
  localparam int GREEN_OFF = 3 * PIO_W;
  localparam int BLUE_OFF = 2 * PIO_W;
  localparam int FOG_OFF = 1 * PIO_W;
  localparam int COLOR_EN_OFF = 0;
  // lookat_r_c words follow eye_z in row-major order, so lookat_1_1 sits at word 13
  function automatic int lookat_off(input int r, input int c);
    return (13 - 3 * (r - 1) - (c - 1)) * PIO_W;
  endfunction
endpackage

// File: rtl/raymarch_frame_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wraparound
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);
  // scan farthest-first so the nearest requester to ptr is the last (winning) write
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        grant = N'(1) << ((int'(ptr) + i) % N);
        idx = PW'((int'(ptr) + i) % N);
      end
  end
endmodule

// File: rtl/raymarch_frame_scheduler.sv
// raymarch_frame_scheduler: per-frame config snapshot, round-robin pixel job dispatch
// and round-robin result arbitration onto the single framebuffer write port.
module raymarch_frame_scheduler
  import raymarch_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int COLOR_W = 8,
  parameter int ADDR_W = 19,
  parameter int CFG_W = CFG_W_DEF,
  parameter int OUT_W = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           run,
  input  logic [CFG_W-1:0]               cfg_in,
  output logic [CFG_W-1:0]               cfg_shadow,
  output logic [NUM_CORES-1:0]           job_valid,
  input  logic [NUM_CORES-1:0]           job_ready,
  output logic [X_W-1:0]                 job_x,
  output logic [Y_W-1:0]                 job_y,
  input  logic [NUM_CORES-1:0]           res_valid,
  output logic [NUM_CORES-1:0]           res_ready,
  input  logic [NUM_CORES*X_W-1:0]       res_x,
  input  logic [NUM_CORES*Y_W-1:0]       res_y,
  input  logic [NUM_CORES*COLOR_W-1:0]   res_color,
  output logic                           fb_we,
  output logic [ADDR_W-1:0]              fb_addr,
  output logic [COLOR_W-1:0]             fb_wdata,
  output logic                           busy,
  output logic                           frame_done,
  output logic [15:0]                    frame_count
);
  localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  state_t state, state_n;
  logic [PW-1:0] dptr, rptr, didx, ridx;
  logic [NUM_CORES-1:0] dgrant, rgrant;
  logic [OUT_W-1:0] outstanding;
  logic issue, accept, x_last, last_px;
  logic [X_W-1:0] rx;
  logic [Y_W-1:0] ry;
  logic [COLOR_W-1:0] rc;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return i == PW'(NUM_CORES - 1) ? '0 : i + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_CORES)) u_dispatch_arb (
    .req(job_ready), .ptr(dptr), .grant(dgrant), .idx(didx)
  );
  // results are refused while reset is held so no accept can leak out of reset
  rr_arbiter #(.N(NUM_CORES)) u_result_arb (
    .req(res_valid & {NUM_CORES{reset_n}}), .ptr(rptr), .grant(rgrant), .idx(ridx)
  );

  assign job_valid = state == DISPATCH ? dgrant : '0;
  assign res_ready = rgrant;
  assign issue = |job_valid;
  assign accept = |rgrant;
  assign x_last = job_x == X_W'(H_RES - 1);
  assign last_px = x_last && job_y == Y_W'(V_RES - 1);
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  assign rx = res_x[ridx*X_W +: X_W];
  assign ry = res_y[ridx*Y_W +: Y_W];
  assign rc = res_color[ridx*COLOR_W +: COLOR_W];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = run ? LATCH : IDLE;
      LATCH:    state_n = DISPATCH;
      DISPATCH: state_n = issue && last_px ? DRAIN : DISPATCH;
      DRAIN:    state_n = outstanding == '0 ? DONE : DRAIN;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cfg_shadow <= '0;
      job_x <= '0;
      job_y <= '0;
      dptr <= '0;
      rptr <= '0;
      outstanding <= '0;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_wdata <= '0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      if (state == LATCH) begin
        cfg_shadow <= cfg_in;
        job_x <= '0;
        job_y <= '0;
      end
      if (issue) begin
        dptr <= next_ptr(didx);
        job_x <= x_last ? '0 : job_x + 1'b1;
        if (x_last) job_y <= job_y + 1'b1;
      end
      if (accept) begin
        rptr <= next_ptr(ridx);
        fb_addr <= ADDR_W'(ry) * ADDR_W'(H_RES) + ADDR_W'(rx);
        fb_wdata <= rc;
      end
      // a simultaneous issue and accept cancel out
      if (issue != accept) outstanding <= issue ? outstanding + 1'b1 : outstanding - 1'b1;
      fb_we <= accept;
      if (state == DONE) frame_count <= frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// tb_raymarch_frame_scheduler: table-driven dispatch/result vectors plus directed multi-frame sequences
module tb_raymarch_frame_scheduler;
  localparam int NC = 2, HR = 4, VR = 2, XW = 10, YW = 9, CW = 8, AW = 19, CFGW = 544, NV = 23;
  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0;
  logic [CFGW-1:0] cfg_in = '0, cfg_shadow;
  logic [NC-1:0] job_valid, res_ready, job_ready = '0, res_valid = '0;
  logic [XW-1:0] job_x;
  logic [YW-1:0] job_y;
  logic [NC*XW-1:0] res_x = '0;
  logic [NC*YW-1:0] res_y = '0;
  logic [NC*CW-1:0] res_color = '0;
  logic fb_we, busy, frame_done;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_wdata;
  logic [15:0] frame_count;
  int checks = 0, failures = 0;
  logic auto_mode = 1'b0;
  int cyc = 0;
  int qx[NC][16], qy[NC][16], qdue[NC][16], qh[NC], qt[NC];
  int n_issue, n_fb, n_done, done_cyc, last_fb_cyc;
  int iss_core[16], iss_x[16], iss_y[16], iss_cyc[16];
  logic [7:0] fb_seen;
  logic [CFGW-1:0] cfg_t = {17{32'hCAFE_0001}}, cfg_a = {17{32'hA5A5_1111}}, cfg_b = {17{32'h0B0E_2222}};

  typedef struct {
    logic rst_n, run;
    logic [1:0] jr, rv;
    int x0, y0, x1, y1;
    logic [1:0] ejv, err;
    logic efw;
    int eaddr, ejx, ejy;
    logic ebusy, efd;
  } vec_t;
  vec_t tv[NV];

  raymarch_frame_scheduler #(
    .NUM_CORES(NC), .H_RES(HR), .V_RES(VR), .X_W(XW), .Y_W(YW),
    .COLOR_W(CW), .ADDR_W(AW), .CFG_W(CFGW), .OUT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .cfg_in(cfg_in), .cfg_shadow(cfg_shadow),
    .job_valid(job_valid), .job_ready(job_ready), .job_x(job_x), .job_y(job_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_color(res_color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic rst_n, input logic rn, input logic [1:0] jr, input logic [1:0] rv,
                              input int x0, input int y0, input int x1, input int y1,
                              input logic [1:0] ejv, input logic [1:0] err, input logic efw, input int eaddr,
                              input int ejx, input int ejy, input logic ebusy, input logic efd);
    vec_t v;
    v.rst_n = rst_n; v.run = rn; v.jr = jr; v.rv = rv;
    v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
    v.ejv = ejv; v.err = err; v.efw = efw; v.eaddr = eaddr;
    v.ejx = ejx; v.ejy = ejy; v.ebusy = ebusy; v.efd = efd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_res(input int i, input int x, input int y);
    res_x[i*XW +: XW] = XW'(x);
    res_y[i*YW +: YW] = YW'(y);
    res_color[i*CW +: CW] = CW'(y * HR + x) ^ 8'h5A;
  endtask

  task automatic clr();
    n_issue = 0; n_fb = 0; n_done = 0; done_cyc = 0; last_fb_cyc = 0; fb_seen = '0;
  endtask

  task automatic flush_cores();
    for (int i = 0; i < NC; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    res_valid = '0;
  endtask

  // one clock: observe transfers at negedge, then drive core results after the edge
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      if (job_valid[i]) begin
        if (auto_mode) begin
          qx[i][qt[i]%16] = int'(job_x);
          qy[i][qt[i]%16] = int'(job_y);
          qdue[i][qt[i]%16] = cyc + 3;
          qt[i]++;
        end
        if (n_issue < 16) begin
          iss_core[n_issue] = i; iss_x[n_issue] = int'(job_x);
          iss_y[n_issue] = int'(job_y); iss_cyc[n_issue] = cyc;
        end
        n_issue++;
      end
      if (auto_mode && res_valid[i] && res_ready[i]) qh[i]++;
    end
    if (fb_we) begin
      chk("fb_wdata_vs_addr", {24'd0, fb_wdata}, {24'd0, 8'(fb_addr) ^ 8'h5A});
      if (fb_addr < 8) fb_seen[fb_addr[2:0]] = 1'b1;
      n_fb++;
      last_fb_cyc = cyc;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (reset_n) chk("outstanding_no_wrap", {31'd0, dut.outstanding == 8'hFF}, 0);
    @(posedge clk);
    #1;
    cyc++;
    if (auto_mode)
      for (int i = 0; i < NC; i++) begin
        res_valid[i] = qh[i] < qt[i] && qdue[i][qh[i]%16] <= cyc;
        if (res_valid[i]) set_res(i, qx[i][qh[i]%16], qy[i][qh[i]%16]);
      end
  endtask

  task automatic run_frame(input logic [1:0] jr, input int run_ticks);
    clr();
    job_ready = jr;
    run = 1'b1;
    for (int k = 0; k < run_ticks; k++) tick();
    run = 1'b0;
    for (int b = 0; b < 200 && n_done == 0; b++) tick();
  endtask

  initial begin
    tv[0]  = mk(0, 1, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(1, 1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
    tv[3]  = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0);
    tv[4]  = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0, 1, 0);
    tv[5]  = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 2, 0, 1, 0);
    tv[6]  = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 3, 0, 1, 0);
    tv[7]  = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 1, 0);
    tv[8]  = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 1, 1, 0);
    tv[9]  = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 2, 1, 1, 0);
    tv[10] = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 3, 1, 1, 0);
    tv[11] = mk(1, 0, 2'b11, 2'b11, 0, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0);
    tv[12] = mk(1, 0, 2'b11, 2'b11, 2, 0, 1, 0, 2'b00, 2'b10, 1, 0, 0, 0, 1, 0);
    tv[13] = mk(1, 0, 2'b11, 2'b11, 2, 0, 3, 0, 2'b00, 2'b01, 1, 1, 0, 0, 1, 0);
    tv[14] = mk(1, 0, 2'b11, 2'b11, 0, 1, 3, 0, 2'b00, 2'b10, 1, 2, 0, 0, 1, 0);
    tv[15] = mk(1, 0, 2'b11, 2'b00, 0, 1, 1, 1, 2'b00, 2'b00, 1, 3, 0, 0, 1, 0);
    tv[16] = mk(1, 0, 2'b11, 2'b10, 0, 1, 1, 1, 2'b00, 2'b10, 0, 0, 0, 0, 1, 0);
    tv[17] = mk(1, 0, 2'b11, 2'b01, 0, 1, 3, 1, 2'b00, 2'b01, 1, 5, 0, 0, 1, 0);
    tv[18] = mk(1, 0, 2'b11, 2'b11, 2, 1, 3, 1, 2'b00, 2'b10, 1, 4, 0, 0, 1, 0);
    tv[19] = mk(1, 0, 2'b11, 2'b01, 2, 1, 3, 1, 2'b00, 2'b01, 1, 7, 0, 0, 1, 0);
    tv[20] = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 6, 0, 0, 1, 0);
    tv[21] = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
    tv[22] = mk(1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    flush_cores();

    reset_n = 1'b0; run = 1'b1; job_ready = 2'b11; res_valid = 2'b11; cfg_in = cfg_b;
    set_res(0, 3, 1); set_res(1, 2, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_job_valid", {30'd0, job_valid}, 0);
    chk("rst_res_ready", {30'd0, res_ready}, 0);
    chk("rst_job_xy", {job_y, 3'd0, job_x}, 0);
    chk("rst_fb", {fb_we, 4'd0, fb_addr, fb_wdata}, 0);
    chk("rst_busy_done", {busy, frame_done}, 0);
    chk("rst_frame_count", {16'd0, frame_count}, 0);
    chk("rst_cfg_shadow", {31'd0, cfg_shadow == '0}, 1);
    @(posedge clk);
    #1;
    cfg_in = cfg_t;

    for (int r = 0; r < NV; r++) begin
      reset_n = tv[r].rst_n; run = tv[r].run; job_ready = tv[r].jr; res_valid = tv[r].rv;
      set_res(0, tv[r].x0, tv[r].y0);
      set_res(1, tv[r].x1, tv[r].y1);
      @(negedge clk);
      chk($sformatf("r%0d_job_valid", r), {30'd0, job_valid}, {30'd0, tv[r].ejv});
      chk($sformatf("r%0d_res_ready", r), {30'd0, res_ready}, {30'd0, tv[r].err});
      chk($sformatf("r%0d_fb_we", r), {31'd0, fb_we}, {31'd0, tv[r].efw});
      chk($sformatf("r%0d_busy", r), {31'd0, busy}, {31'd0, tv[r].ebusy});
      chk($sformatf("r%0d_frame_done", r), {31'd0, frame_done}, {31'd0, tv[r].efd});
      if (tv[r].ejv != 2'b00) begin
        chk($sformatf("r%0d_job_x", r), {22'd0, job_x}, tv[r].ejx);
        chk($sformatf("r%0d_job_y", r), {23'd0, job_y}, tv[r].ejy);
      end
      if (tv[r].efw) begin
        chk($sformatf("r%0d_fb_addr", r), {13'd0, fb_addr}, tv[r].eaddr);
        chk($sformatf("r%0d_fb_wdata", r), {24'd0, fb_wdata}, {24'd0, 8'(tv[r].eaddr) ^ 8'h5A});
      end
      @(posedge clk);
      #1;
    end
    chk("tab_frame_count", {16'd0, frame_count}, 1);
    chk("tab_cfg_shadow", {31'd0, cfg_shadow == cfg_t}, 1);

    auto_mode = 1'b1;
    flush_cores();
    run_frame(2'b11, 1);
    chk("s1_jobs", n_issue, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s1_core_%0d", k), iss_core[k], k % 2);
      chk($sformatf("s1_x_%0d", k), iss_x[k], k % HR);
      chk($sformatf("s1_y_%0d", k), iss_y[k], k / HR);
      chk($sformatf("s1_consec_%0d", k), iss_cyc[k] - iss_cyc[0], k);
    end
    chk("s1_fb_set", {24'd0, fb_seen}, 32'hFF);
    chk("s1_fb_count", n_fb, 8);
    chk("s1_done", n_done, 1);
    chk("s1_done_after_fb", {31'd0, done_cyc > last_fb_cyc}, 1);
    chk("s1_frame_count", {16'd0, frame_count}, 2);
    repeat (3) tick();
    chk("s1_idle", {31'd0, busy}, 0);

    run_frame(2'b01, 1);
    begin
      int c0 = 0;
      for (int k = 0; k < 8; k++) if (iss_core[k] == 0) c0++;
      chk("s2_core0_jobs", c0, 8);
    end
    chk("s2_jobs", n_issue, 8);
    chk("s2_fb_set", {24'd0, fb_seen}, 32'hFF);
    chk("s2_done", n_done, 1);
    chk("s2_outstanding", {24'd0, dut.outstanding}, 0);
    chk("s2_frame_count", {16'd0, frame_count}, 3);

    clr(); job_ready = 2'b11; cfg_in = cfg_a; run = 1'b1;
    tick(); tick();
    cfg_in = cfg_b; run = 1'b0;
    for (int b = 0; b < 200 && n_done == 0; b++) tick();
    chk("s3_done_a", n_done, 1);
    chk("s3_shadow_a", {31'd0, cfg_shadow == cfg_a}, 1);
    repeat (2) tick();
    chk("s3_shadow_a_idle", {31'd0, cfg_shadow == cfg_a}, 1);
    clr(); run = 1'b1;
    tick(); tick();
    run = 1'b0;
    chk("s3_shadow_b", {31'd0, cfg_shadow == cfg_b}, 1);
    for (int b = 0; b < 200 && n_done == 0; b++) tick();
    chk("s3_done_b", n_done, 1);
    chk("s3_frame_count", {16'd0, frame_count}, 5);

    run_frame(2'b11, 4);
    chk("s4_jobs", n_issue, 8);
    chk("s4_done", n_done, 1);
    repeat (4) tick();
    chk("s4_idle", {31'd0, busy}, 0);
    chk("s4_no_new_frame", n_done, 1);
    chk("s4_frame_count", {16'd0, frame_count}, 6);

    reset_n = 1'b0;
    tick(); tick();
    flush_cores();
    reset_n = 1'b1;
    chk("s5_count_pre", {16'd0, frame_count}, 0);
    clr(); run = 1'b1;
    repeat (5) tick();
    chk("s5_partial_jobs", n_issue, 3);
    reset_n = 1'b0; run = 1'b0;
    @(posedge clk);
    #1;
    chk("s5_job_valid", {30'd0, job_valid}, 0);
    chk("s5_busy", {31'd0, busy}, 0);
    chk("s5_res_ready", {30'd0, res_ready}, 0);
    chk("s5_frame_count", {16'd0, frame_count}, 0);
    flush_cores();
    reset_n = 1'b1;
    clr();
    repeat (4) tick();
    chk("s5_stays_idle", {31'd0, busy}, 0);
    chk("s5_no_done", n_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
